// File: rtl/sobel_gradient_engine_if.sv
// Window-in / pixel-out bundle between sobel_data_buffer, the gradient engine
// and the output image writer.
interface sobel_gradient_engine_if;
    logic [7:0] d0_i;
    logic [7:0] d1_i;
    logic [7:0] d2_i;
    logic [7:0] d3_i;
    logic [7:0] d4_i;
    logic [7:0] d5_i;
    logic [7:0] d6_i;
    logic [7:0] d7_i;
    logic [7:0] d8_i;
    logic       done_i;
    logic [7:0] mag_o;
    logic [7:0] edge_o;
    logic       done_o;
    logic       frame_done_o;

    modport master (
        output d0_i, d1_i, d2_i, d3_i, d4_i, d5_i, d6_i, d7_i, d8_i, done_i,
        input  mag_o, edge_o, done_o, frame_done_o
    );

    modport slave (
        input  d0_i, d1_i, d2_i, d3_i, d4_i, d5_i, d6_i, d7_i, d8_i, done_i,
        output mag_o, edge_o, done_o, frame_done_o
    );
endinterface

// File: rtl/sobel_gradient_engine.sv
// Sobel gradient magnitude and thresholded edge pixel per 3x3 window, with an
// output-pixel counter that pulses frame_done_o on the last pixel of a frame.
module sobel_gradient_engine #(
    parameter int THRESHOLD  = 100,
    parameter int OUT_PIXELS = 64516,
    parameter int CNT_W      = 17
) (
    input logic                    clk,
    input logic                    rst,
    sobel_gradient_engine_if.slave win
);

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(OUT_PIXELS - 1);
    localparam logic [31:0]      THR_W    = 32'(THRESHOLD);

    function automatic logic [9:0] abs_grad(input logic signed [10:0] v);
        return v[10] ? 10'(-v) : v[9:0];
    endfunction

    function automatic logic [7:0] sat_mag(input logic [10:0] s);
        return (s > 11'd255) ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [7:0] edge_of(input logic [7:0] m);
        return (32'(m) >= THR_W) ? 8'hFF : 8'h00;
    endfunction

    // Centre pixel carries zero weight in both kernels.
    logic win_unused;
    assign win_unused = ^win.d4_i;

    logic [9:0]        gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [10:0] gx, gy;

    assign gx_pos = {2'b00, win.d2_i} + {1'b0, win.d5_i, 1'b0} + {2'b00, win.d8_i};
    assign gx_neg = {2'b00, win.d0_i} + {1'b0, win.d3_i, 1'b0} + {2'b00, win.d6_i};
    assign gy_pos = {2'b00, win.d6_i} + {1'b0, win.d7_i, 1'b0} + {2'b00, win.d8_i};
    assign gy_neg = {2'b00, win.d0_i} + {1'b0, win.d1_i, 1'b0} + {2'b00, win.d2_i};
    assign gx     = signed'({1'b0, gx_pos}) - signed'({1'b0, gx_neg});
    assign gy     = signed'({1'b0, gy_pos}) - signed'({1'b0, gy_neg});

    logic signed [10:0] gx_p0, gy_p0;
    logic [9:0]         abs_gx_p1, abs_gy_p1;
    logic [10:0]        sum_p2;
    logic [7:0]         mag_p3, edge_p3;
    logic               vld_p0, vld_p1, vld_p2, vld_p3;
    logic [CNT_W-1:0]   pix_cnt;
    logic               last_pix;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            vld_p3    <= 1'b0;
            gx_p0     <= '0;
            gy_p0     <= '0;
            abs_gx_p1 <= '0;
            abs_gy_p1 <= '0;
            sum_p2    <= '0;
            mag_p3    <= '0;
            edge_p3   <= '0;
        end else begin
            // p0: signed gradients
            vld_p0 <= win.done_i;
            if (win.done_i) begin
                gx_p0 <= gx;
                gy_p0 <= gy;
            end
            // p1: magnitudes of each gradient
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                abs_gx_p1 <= abs_grad(gx_p0);
                abs_gy_p1 <= abs_grad(gy_p0);
            end
            // p2: L1 gradient sum
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                sum_p2 <= {1'b0, abs_gx_p1} + {1'b0, abs_gy_p1};
            end
            // p3: saturate, threshold and hold the pixel on the output
            vld_p3 <= vld_p2;
            if (vld_p2) begin
                mag_p3  <= sat_mag(sum_p2);
                edge_p3 <= edge_of(sat_mag(sum_p2));
            end
        end
    end

    assign last_pix = vld_p3 && (pix_cnt == LAST_PIX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_cnt <= '0;
        end else if (vld_p3) begin
            pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
        end
    end

    assign win.mag_o        = mag_p3;
    assign win.edge_o       = edge_p3;
    assign win.done_o       = vld_p3;
    assign win.frame_done_o = last_pix;

endmodule
